// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types for the iterative multiply/divide unit.
//   op_e    - RISC-V M-extension funct3 encodings (all eight values defined)
//   state_e - control FSM states
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the pipeline and the muldiv unit.
//   start  - request a new operation (sampled only when the unit is idle)
//   flush  - abort any operation in progress
//   op     - funct3 operation select
//   a, b   - rs1 / rs2 operands
//   busy   - operation accepted and still iterating
//   done   - one-cycle result-valid pulse
//   result - result, held from done until the next accepted start
interface muldiv_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  start;
   logic                  flush;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] result;

   modport master (
      output start, flush, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, op, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative multiplier/divider for the RISC-V M extension.
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous active-high reset
//   bus   - slave side of muldiv_unit_if (start/flush/op/a/b in; busy/done/result out)
// One DATA_WIDTH+1-bit adder is shared: shift-add for multiply, restoring
// shift-subtract for divide (op[2] selects). Signed ops run on magnitudes and the
// result is negated at the end. Divide-by-zero and signed overflow bypass CALC.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam int unsigned W    = DATA_WIDTH;
   localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CntW-1:0] LastIter = CntW'(DATA_WIDTH - 1);

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic [2:0]      r_op;
   logic            r_neg;
   logic [W-1:0]    r_hi;     // product high half / partial remainder
   logic [W-1:0]    r_lo;     // multiplier then product low half / dividend then quotient
   logic [W-1:0]    r_opnd;   // multiplicand / divisor magnitude
   logic [W-1:0]    r_result;
   logic            r_busy;
   logic            r_done;

   // Operand conditioning at accept time
   logic         w_a_sgn, w_b_sgn, w_neg;
   logic [W-1:0] w_a_mag, w_b_mag;
   logic         w_div_zero, w_ovf;
   logic [W-1:0] w_special;

   always_comb begin
      w_a_sgn = 1'b0;
      w_b_sgn = 1'b0;
      w_neg   = 1'b0;
      unique case (op_e'(bus.op))
         OpMul, OpMulh, OpDiv: begin
            w_a_sgn = 1'b1;
            w_b_sgn = 1'b1;
            w_neg   = bus.a[W-1] ^ bus.b[W-1];
         end
         OpMulhsu: begin
            w_a_sgn = 1'b1;
            w_neg   = bus.a[W-1];
         end
         OpRem: begin
            w_a_sgn = 1'b1;
            w_b_sgn = 1'b1;
            w_neg   = bus.a[W-1];
         end
         OpMulhu, OpDivu, OpRemu: ;
      endcase
   end

   assign w_a_mag    = (w_a_sgn && bus.a[W-1]) ? -bus.a : bus.a;
   assign w_b_mag    = (w_b_sgn && bus.b[W-1]) ? -bus.b : bus.b;
   assign w_div_zero = bus.op[2] && (bus.b == '0);
   // Only signed DIV/REM (op[0]=0) can overflow
   assign w_ovf      = bus.op[2] && !bus.op[0] && (bus.a == {1'b1, {(W-1){1'b0}}})
                       && (bus.b == '1);

   always_comb begin
      if (w_div_zero) w_special = bus.op[1] ? bus.a : '1;
      else            w_special = bus.op[1] ? '0 : bus.a;
   end

   // Shared adder/subtractor
   logic [W:0]   w_lhs, w_rhs, w_sum;
   logic         w_cin, w_borrow;
   logic [W-1:0] w_hi_nxt, w_lo_nxt;

   always_comb begin
      if (r_op[2]) begin
         w_lhs = {r_hi, r_lo[W-1]};
         w_rhs = ~{1'b0, r_opnd};
         w_cin = 1'b1;
      end else begin
         w_lhs = {1'b0, r_hi};
         w_rhs = r_lo[0] ? {1'b0, r_opnd} : '0;
         w_cin = 1'b0;
      end
   end

   assign w_sum    = w_lhs + w_rhs + {{W{1'b0}}, w_cin};
   // Partial remainder < divisor, so bit W of the difference is the borrow
   assign w_borrow = w_sum[W];

   always_comb begin
      if (r_op[2]) begin
         w_hi_nxt = w_borrow ? w_lhs[W-1:0] : w_sum[W-1:0];
         w_lo_nxt = {r_lo[W-2:0], ~w_borrow};
      end else begin
         w_hi_nxt = w_sum[W:1];
         w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
      end
   end

   // Sign fix-up applied on the last iteration's values
   logic [2*W-1:0] w_prod, w_prod_s;
   logic [W-1:0]   w_quot_s, w_rem_s, w_final;

   always_comb begin
      w_prod   = {w_hi_nxt, w_lo_nxt};
      w_prod_s = r_neg ? -w_prod : w_prod;
      w_quot_s = r_neg ? -w_lo_nxt : w_lo_nxt;
      w_rem_s  = r_neg ? -w_hi_nxt : w_hi_nxt;
      w_final  = '0;
      unique case (op_e'(r_op))
         OpMul:                     w_final = w_prod_s[W-1:0];
         OpMulh, OpMulhsu, OpMulhu: w_final = w_prod_s[2*W-1:W];
         OpDiv, OpDivu:             w_final = w_quot_s;
         OpRem, OpRemu:             w_final = w_rem_s;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opnd   <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else if (bus.flush) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_op  <= bus.op;
                  r_neg <= w_neg;
                  r_cnt <= '0;
                  if (w_div_zero || w_ovf) begin
                     r_result <= w_special;
                     r_done   <= 1'b1;
                     r_state  <= StDone;
                  end else begin
                     r_hi    <= '0;
                     r_lo    <= w_a_mag;
                     r_opnd  <= w_b_mag;
                     r_busy  <= 1'b1;
                     r_state <= StCalc;
                  end
               end
            end
            StCalc: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + CntW'(1);
               if (r_cnt == LastIter) begin
                  r_result <= w_final;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= StDone;
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// A latency/arithmetic model predicts busy, done and result every cycle; directed
// cases pin literal values, then a randomized run exercises all ops with flushes
// and stray start pulses.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk;
   logic reset;

   muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic from the ISA definition
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa, sb, p_ss, p_su, q_s, r_s;
      logic [63:0]        ua, ub, p_uu;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ua   = {32'd0, a};
      ub   = {32'd0, b};
      p_ss = sa * sb;
      p_su = sa * $signed(ub);
      p_uu = ua * ub;
      case (op)
         3'b000: return p_ss[31:0];
         3'b001: return p_ss[63:32];
         3'b010: return p_su[63:32];
         3'b011: return p_uu[63:32];
         default: begin
            if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return op[1] ? 32'd0 : a;
            q_s = sa / sb;
            r_s = sa % sb;
            case (op)
               3'b100:  return q_s[31:0];
               3'b101:  return 32'(ua / ub);
               3'b110:  return r_s[31:0];
               default: return 32'(ua % ub);
            endcase
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      return op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Cycle-level expectation: accepted op occupies 32 busy cycles then one done cycle,
   // or a single done cycle for the bypass cases.
   logic        m_busy, m_done;
   int          m_left;
   logic [31:0] m_val, m_res;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
         m_val  <= '0;
         m_res  <= '0;
      end else if (bus.flush) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_res  <= m_val;
         end
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (bus.start) begin
         if (is_special(bus.op, bus.a, bus.b)) begin
            m_done <= 1'b1;
            m_res  <= ref_result(bus.op, bus.a, bus.b);
         end else begin
            m_busy <= 1'b1;
            m_left <= 32;
            m_val  <= ref_result(bus.op, bus.a, bus.b);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            check("done", {31'd0, bus.done}, {31'd0, m_done});
            if (!m_busy) check("result", bus.result, m_res);
         end
      end
   end

   // Issue one op and observe ncyc cycles; optional stray start at start_k, flush at flush_k
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int start_k, input int flush_k, input int ncyc,
                         output int lat, output logic [31:0] res, output int busy_n,
                         output int done_n);
      lat    = 0;
      res    = '0;
      busy_n = 0;
      done_n = 0;
      @(negedge clk);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (bus.busy) busy_n++;
         if (bus.done) begin
            done_n++;
            if (lat == 0) begin
               lat = k;
               res = bus.result;
            end
         end
         bus.start = (k == start_k);
         if (k == start_k) begin
            bus.a = ~a;
            bus.b = b ^ 32'h5;
         end
         bus.flush = (k == flush_k);
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
   endtask

   int          lat, bn, dn;
   logic [31:0] res, prev;

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_result", bus.result, 32'd0);

      // Pin the reference model itself
      check("model_mulhu", ref_result(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      check("model_div", ref_result(OpDiv, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("model_rem", ref_result(OpRem, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check("model_mulhsu", ref_result(OpMulhsu, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);

      @(posedge clk);
      #1 reset = 1'b0;

      run_op(OpMul, 32'd7, 32'd6, 0, 0, 36, lat, res, bn, dn);
      check("mul_lat", lat, 32'd33);
      check("mul_res", res, 32'd42);
      check("mul_busy_cycles", bn, 32'd32);
      check("mul_done_count", dn, 32'd1);

      run_op(OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 36, lat, res, bn, dn);
      check("mulh_res", res, 32'h0000_0000);
      run_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 36, lat, res, bn, dn);
      check("mulhu_res", res, 32'hFFFF_FFFE);
      run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 0, 0, 36, lat, res, bn, dn);
      check("div_res", res, 32'hFFFF_FFFD);
      run_op(OpRem, 32'hFFFF_FFF9, 32'd2, 0, 0, 36, lat, res, bn, dn);
      check("rem_res", res, 32'hFFFF_FFFF);

      run_op(OpDivu, 32'd5, 32'd0, 0, 0, 4, lat, res, bn, dn);
      check("divz_lat", lat, 32'd1);
      check("divz_res", res, 32'hFFFF_FFFF);
      run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 4, lat, res, bn, dn);
      check("ovf_lat", lat, 32'd1);
      check("ovf_res", res, 32'h8000_0000);

      // Flush at cycle 10, restart at cycle 12
      prev = bus.result;
      run_op(OpDiv, 32'd100, 32'd3, 0, 10, 11, lat, res, bn, dn);
      check("flush_no_done", dn, 32'd0);
      check("flush_idle", {31'd0, bus.busy}, 32'd0);
      check("flush_hold", bus.result, prev);
      run_op(OpDivu, 32'd100, 32'd7, 0, 0, 36, lat, res, bn, dn);
      check("after_flush_lat", lat, 32'd33);
      check("after_flush_res", res, 32'd14);

      // Stray start during CALC is ignored
      run_op(OpMul, 32'd3, 32'd5, 5, 0, 40, lat, res, bn, dn);
      check("busy_start_done_count", dn, 32'd1);
      check("busy_start_res", res, 32'd15);

      // Flush wins over start in IDLE
      @(negedge clk);
      bus.op    = OpMul;
      bus.a     = 32'd1;
      bus.b     = 32'd1;
      bus.start = 1'b1;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("flush_prio_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_prio_done", {31'd0, bus.done}, 32'd0);

      // Reset mid-CALC clears outputs without a clock edge
      @(negedge clk);
      bus.op    = OpMul;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_mid_done", {31'd0, bus.done}, 32'd0);
      check("rst_mid_result", bus.result, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      run_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 36, lat, res, bn, dn);
      check("post_reset_lat", lat, 32'd33);
      check("post_reset_res", res, 32'hFFFF_FFFE);

      // Randomized run; per-cycle checks come from the model
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  r_op;
         logic [31:0] r_a, r_b;
         int          sel, fk, sk;
         r_op = 3'($urandom_range(7, 0));
         r_a  = $urandom;
         r_b  = $urandom;
         sel  = $urandom_range(9, 0);
         if (sel == 0) r_b = 32'd0;
         else if (sel == 1) begin
            r_a = 32'h8000_0000;
            r_b = 32'hFFFF_FFFF;
         end
         else if (sel == 2) r_b = 32'($urandom_range(15, 1));
         else if (sel == 3) r_a = 32'($urandom_range(100, 0));
         fk = 0;
         sk = 0;
         if (!is_special(r_op, r_a, r_b)) begin
            if ($urandom_range(5, 0) == 0) fk = $urandom_range(33, 1);
            else if ($urandom_range(5, 0) == 0) sk = $urandom_range(31, 2);
         end
         run_op(r_op, r_a, r_b, sk, fk, 36, lat, res, bn, dn);
         if (fk == 0) begin
            check("rand_done_count", dn, 32'd1);
            check("rand_res", res, ref_result(r_op, r_a, r_b));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width. Only 32 is verified.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port flush, input, 1: abort any operation in progress (pipeline flush).
REQ-006 SHALL have port op, input, 3: RISC-V M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have ports a and b, input, DATA_WIDTH: rs1 and rs2 operands; sampled with start.
REQ-008 SHALL have port busy, output, 1: high while an accepted operation is not yet complete.
REQ-009 SHALL have port done, output, 1: one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, DATA_WIDTH: feeds one input of the writeback result-select mux.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-012 SHALL transition IDLE->CALC when start=1 and flush=0; a, b and op are latched on that edge.
REQ-013 SHALL complete CALC in exactly DATA_WIDTH iterations: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). It then goes to DONE.
REQ-014 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-015 SHALL therefore give a normal latency in which done is high DATA_WIDTH+1 cycles after the cycle in which start was sampled.
REQ-016 SHALL hold busy=1 in CALC only; busy=0 in IDLE and DONE.
REQ-017 SHALL keep result stable from the DONE cycle until the next accepted start.
REQ-018 SHALL compute signed operations on operand magnitudes, then conditionally negate the result (two's complement):
  - MUL, MULH: sign of a XOR sign of b.
  - MULHSU: sign of a only.
  - DIV: sign of a XOR sign of b.
  - REM: sign of a.
REQ-019 SHALL return the low DATA_WIDTH bits of the 2*DATA_WIDTH-bit product for MUL, and the high bits for MULH, MULHSU and MULHU.
REQ-020 SHALL handle divide by zero (b=0) as follows:
  - DIV/DIVU result = all ones.
  - REM/REMU result = a.
  - The FSM goes IDLE->DONE directly, so done is high 1 cycle after start.
REQ-021 SHALL handle signed overflow (DIV/REM with a=most-negative, b=all ones) as follows:
  - DIV result = a; REM result = 0.
  - The FSM goes IDLE->DONE directly, so done is high 1 cycle after start.
REQ-022 SHALL ignore start while in CALC or DONE; no queuing.
REQ-023 SHALL respond to flush=1 in any state by entering IDLE on the next edge: done is not asserted and result holds its prior value.
REQ-024 SHALL give flush priority over start when both are asserted in IDLE; nothing is accepted.
REQ-025 SHALL treat op values as exhaustive: no undefined encodings.

Reset
REQ-026 SHALL force, on reset assertion, without waiting for clk: state=IDLE, busy=0, done=0, result=0, iteration counter=0, all datapath registers=0.
REQ-027 SHALL discard, on reset asserted mid-CALC, the operation in progress without producing done.
REQ-028 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place in the shared core package: the muldiv op enum (funct3 values above) and the FSM state enum.
REQ-030 SHALL size the iteration counter as $clog2(DATA_WIDTH)+1 bits, derived from DATA_WIDTH.
REQ-031 SHALL be a single module with no sub-modules: shift-add and shift-subtract share one DATA_WIDTH+1-bit adder/subtractor, selected by op[2].

Verification
REQ-032 SHALL verify MUL: a=7, b=6, start -> done at cycle 33, result=42; busy high cycles 1-32.
REQ-033 SHALL verify MULH/MULHU: a=0xFFFFFFFF, b=0xFFFFFFFF:
  - MULH -> result=0x00000000.
  - MULHU -> result=0xFFFFFFFE.
REQ-034 SHALL verify DIV/REM: a=-7 (0xFFFFFFF9), b=2:
  - DIV -> result=0xFFFFFFFD (-3).
  - REM -> result=0xFFFFFFFF (-1).
REQ-035 SHALL verify special cases:
  - DIVU a=5, b=0 -> done 1 cycle later, result=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, 1-cycle latency.
REQ-036 SHALL verify flush: flush at cycle 10 of a DIV -> IDLE next cycle, no done pulse, result unchanged. A new start at cycle 12 then completes normally.
REQ-037 SHALL verify reset and start-while-busy:
  - Reset asserted mid-CALC -> busy/done/result=0 immediately.
  - start pulsed during CALC -> ignored: exactly one done, original operands' result.
